// File: rtl/mfp_ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the write-buffer entry layout used by the
// SREC loader stages.
package mfp_ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_8  = 3'b000;
  localparam logic [2:0] HSIZE_16 = 3'b001;
  localparam logic [2:0] HSIZE_32 = 3'b010;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

endpackage

// File: rtl/mfp_srec_ahb_writer_if.sv
// Byte-write strobe from the SREC parser plus the AHB-Lite master bus it is
// turned into; master = the writer, slave = the parser/bus side.
interface mfp_srec_ahb_writer_if;

  logic [31:0] write_address;
  logic [7:0]  write_byte;
  logic        write_enable;

  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  write_address, write_byte, write_enable, HREADY, HRESP,
    output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE
  );

  modport slave (
    output write_address, write_byte, write_enable, HREADY, HRESP,
    input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE
  );

endinterface

// File: rtl/mfp_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is only
// accepted when a pop happens on the same edge.
module mfp_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/mfp_srec_ahb_writer.sv
// Buffers SREC parser byte writes and issues them as pipelined AHB-Lite
// single byte writes (address phase A, data phase D), honouring HREADY.
module mfp_srec_ahb_writer
  import mfp_ahb_lite_pkg::*;
#(
  parameter int         FIFO_AW   = 2,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                  clock,
  input  logic                  reset_n,
  mfp_srec_ahb_writer_if.master bus,
  output logic                  busy,
  output logic                  overflow,
  output logic                  bus_error
);

  wr_entry_t   w_wr_entry;
  wr_entry_t   w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_advance;
  logic        w_pop;

  logic        r_a_vld;
  logic [31:0] r_a_addr;
  logic [7:0]  r_a_byte;
  logic        r_d_vld;
  logic [31:0] r_hwdata;
  logic        r_overflow;
  logic        r_bus_error;

  assign w_wr_entry = '{addr: bus.write_address, data: bus.write_byte};

  // No data phase pending means the bus is ours to advance regardless of HREADY.
  assign w_advance = bus.HREADY | ~r_d_vld;
  assign w_pop     = w_advance & ~w_empty;

  mfp_sync_fifo #(
    .WIDTH ($bits(wr_entry_t)),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (bus.write_enable),
    .i_pop   (w_pop),
    .i_wdata (w_wr_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a_vld     <= 1'b0;
      r_a_addr    <= '0;
      r_a_byte    <= '0;
      r_d_vld     <= 1'b0;
      r_hwdata    <= '0;
      r_overflow  <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      if (w_advance) begin
        r_d_vld <= r_a_vld;
        if (r_a_vld) r_hwdata <= {4{r_a_byte}};
        if (!w_empty) begin
          r_a_vld  <= 1'b1;
          r_a_addr <= w_head.addr;
          r_a_byte <= w_head.data;
        end else begin
          r_a_vld  <= 1'b0;
        end
      end
      if (bus.write_enable && w_full && !w_pop) r_overflow <= 1'b1;
      // Errored transfers are reported, never retried.
      if (r_d_vld && bus.HREADY && bus.HRESP) r_bus_error <= 1'b1;
    end
  end

  assign bus.HADDR     = r_a_addr;
  assign bus.HTRANS    = r_a_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HWRITE    = r_a_vld;
  assign bus.HWDATA    = r_hwdata;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HSIZE     = HSIZE_8;

  assign busy      = ~w_empty | r_a_vld | r_d_vld;
  assign overflow  = r_overflow;
  assign bus_error = r_bus_error;

endmodule

// File: tb/tb_mfp_srec_ahb_writer.sv
// Directed bench for mfp_srec_ahb_writer: one task per scenario, hand-computed
// expectations, outputs sampled 1 time unit after each rising edge.
module tb_mfp_srec_ahb_writer;

  logic clock;
  logic reset_n;
  logic busy;
  logic overflow;
  logic bus_error;
  int   n_tests;
  int   n_fail;

  mfp_srec_ahb_writer_if u_bus();

  mfp_srec_ahb_writer #(
    .FIFO_AW   (2),
    .HPROT_VAL (4'b0011)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (u_bus),
    .busy      (busy),
    .overflow  (overflow),
    .bus_error (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    u_bus.write_address = '0;
    u_bus.write_byte    = '0;
    u_bus.write_enable  = 1'b0;
    u_bus.HREADY        = 1'b1;
    u_bus.HRESP         = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic strobe(input logic [31:0] addr, input logic [7:0] data);
    u_bus.write_address = addr;
    u_bus.write_byte    = data;
    u_bus.write_enable  = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset_n = 1'b0;
    #3;
    n_tests++; if (u_bus.HTRANS !== 2'b00) begin n_fail++; $display("FAIL reset_htrans got %h want 0", u_bus.HTRANS); end
    n_tests++; if (u_bus.HWRITE !== 1'b0) begin n_fail++; $display("FAIL reset_hwrite got %b want 0", u_bus.HWRITE); end
    n_tests++; if (u_bus.HADDR !== 32'h0) begin n_fail++; $display("FAIL reset_haddr got %h want 0", u_bus.HADDR); end
    n_tests++; if (u_bus.HWDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hwdata got %h want 0", u_bus.HWDATA); end
    n_tests++; if ({busy, overflow, bus_error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, overflow, bus_error}); end
    n_tests++; if ({u_bus.HBURST, u_bus.HMASTLOCK, u_bus.HPROT, u_bus.HSIZE} !== {3'b000, 1'b0, 4'b0011, 3'b000})
      begin n_fail++; $display("FAIL reset_consts got %b %b %b %b", u_bus.HBURST, u_bus.HMASTLOCK, u_bus.HPROT, u_bus.HSIZE); end
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    strobe(32'h0000_0103, 8'hA5);
    tick();
    u_bus.write_enable = 1'b0;
    n_tests++; if (u_bus.HTRANS !== 2'b00) begin n_fail++; $display("FAIL single_n0_htrans got %h want 0", u_bus.HTRANS); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_n0_busy got %b want 1", busy); end
    tick();
    n_tests++; if (u_bus.HTRANS !== 2'b10) begin n_fail++; $display("FAIL single_htrans got %h want 2", u_bus.HTRANS); end
    n_tests++; if (u_bus.HADDR !== 32'h103) begin n_fail++; $display("FAIL single_haddr got %h want 103", u_bus.HADDR); end
    n_tests++; if ({u_bus.HWRITE, u_bus.HSIZE} !== 4'b1000) begin n_fail++; $display("FAIL single_hwrite_hsize got %b %b want 1 000", u_bus.HWRITE, u_bus.HSIZE); end
    tick();
    n_tests++; if (u_bus.HWDATA !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL single_hwdata got %h want a5a5a5a5", u_bus.HWDATA); end
    n_tests++; if (u_bus.HTRANS !== 2'b00) begin n_fail++; $display("FAIL single_idle_after got %h want 0", u_bus.HTRANS); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_n2_busy got %b want 1", busy); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b [4];
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      if (c <= 4) strobe(32'h100 + 32'(c - 1), b[c-1]);
      else u_bus.write_enable = 1'b0;
      tick();
      if (c >= 2 && c <= 5) begin
        n_tests++; if (u_bus.HTRANS !== 2'b10 || u_bus.HADDR !== 32'h100 + 32'(c - 2))
          begin n_fail++; $display("FAIL b2b_addr c=%0d got %h/%h want 2/%h", c, u_bus.HTRANS, u_bus.HADDR, 32'h100 + 32'(c - 2)); end
      end
      if (c >= 3) begin
        n_tests++; if (u_bus.HWDATA !== {4{b[c-3]}})
          begin n_fail++; $display("FAIL b2b_data c=%0d got %h want %h", c, u_bus.HWDATA, {4{b[c-3]}}); end
      end
      if (c == 6) begin
        n_tests++; if (u_bus.HTRANS !== 2'b00) begin n_fail++; $display("FAIL b2b_end_idle got %h want 0", u_bus.HTRANS); end
      end
    end
  endtask

  task automatic test_wait_states;
    do_reset();
    strobe(32'h300, 8'h55);
    tick();
    strobe(32'h301, 8'h66);
    tick();
    u_bus.write_enable = 1'b0;
    n_tests++; if (u_bus.HADDR !== 32'h300 || u_bus.HTRANS !== 2'b10) begin n_fail++; $display("FAIL ws_first_addr got %h/%h want 300/2", u_bus.HADDR, u_bus.HTRANS); end
    tick();
    n_tests++; if (u_bus.HADDR !== 32'h301 || u_bus.HWDATA !== 32'h5555_5555)
      begin n_fail++; $display("FAIL ws_pre_stall got %h/%h want 301/55555555", u_bus.HADDR, u_bus.HWDATA); end
    u_bus.HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++; if (u_bus.HADDR !== 32'h301 || u_bus.HTRANS !== 2'b10 || u_bus.HWDATA !== 32'h5555_5555)
        begin n_fail++; $display("FAIL ws_hold k=%0d got %h/%h/%h want 301/2/55555555", k, u_bus.HADDR, u_bus.HTRANS, u_bus.HWDATA); end
    end
    u_bus.HREADY = 1'b1;
    tick();
    n_tests++; if (u_bus.HWDATA !== 32'h6666_6666 || u_bus.HTRANS !== 2'b00)
      begin n_fail++; $display("FAIL ws_second_data got %h/%h want 66666666/0", u_bus.HWDATA, u_bus.HTRANS); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ws_done_busy got %b want 0", busy); end
  endtask

  task automatic test_overflow;
    do_reset();
    u_bus.HREADY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      strobe(32'h400 + 32'(i), 8'(8'hB0 + i));
      tick();
      if (i == 5) begin
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", overflow); end
      end
    end
    u_bus.write_enable = 1'b0;
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_tests++; if (u_bus.HADDR !== 32'h401 || u_bus.HWDATA !== 32'hB0B0_B0B0)
      begin n_fail++; $display("FAIL ovf_stalled got %h/%h want 401/b0b0b0b0", u_bus.HADDR, u_bus.HWDATA); end
    u_bus.HREADY = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (j <= 4) begin
        n_tests++; if (u_bus.HWDATA !== {4{8'(8'hB1 + j)}})
          begin n_fail++; $display("FAIL ovf_drain_data j=%0d got %h want %h", j, u_bus.HWDATA, {4{8'(8'hB1 + j)}}); end
      end
      if (j <= 3) begin
        n_tests++; if (u_bus.HTRANS !== 2'b10 || u_bus.HADDR !== 32'h402 + 32'(j))
          begin n_fail++; $display("FAIL ovf_drain_addr j=%0d got %h/%h want 2/%h", j, u_bus.HTRANS, u_bus.HADDR, 32'h402 + 32'(j)); end
      end
      if (j == 4) begin
        n_tests++; if (u_bus.HTRANS !== 2'b00) begin n_fail++; $display("FAIL ovf_dropped_issued got %h want 0", u_bus.HTRANS); end
      end
      if (j == 5) begin
        n_tests++; if (busy !== 1'b0 || overflow !== 1'b1)
          begin n_fail++; $display("FAIL ovf_end got busy=%b ovf=%b want 0/1", busy, overflow); end
      end
    end
  endtask

  task automatic test_bus_error;
    do_reset();
    strobe(32'h200, 8'h77);
    tick();
    strobe(32'h204, 8'h88);
    tick();
    strobe(32'h208, 8'h99);
    tick();
    u_bus.write_enable = 1'b0;
    n_tests++; if (bus_error !== 1'b0 || u_bus.HWDATA !== 32'h7777_7777)
      begin n_fail++; $display("FAIL err_pre got %b/%h want 0/77777777", bus_error, u_bus.HWDATA); end
    u_bus.HRESP = 1'b1;
    tick();
    u_bus.HRESP = 1'b0;
    n_tests++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", bus_error); end
    n_tests++; if (u_bus.HWDATA !== 32'h8888_8888 || u_bus.HADDR !== 32'h208 || u_bus.HTRANS !== 2'b10)
      begin n_fail++; $display("FAIL err_continue got %h/%h/%h want 88888888/208/2", u_bus.HWDATA, u_bus.HADDR, u_bus.HTRANS); end
    tick();
    n_tests++; if (u_bus.HWDATA !== 32'h9999_9999) begin n_fail++; $display("FAIL err_third got %h want 99999999", u_bus.HWDATA); end
    tick();
    n_tests++; if (bus_error !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL err_sticky got err=%b busy=%b want 1/0", bus_error, busy); end
  endtask

  task automatic test_async_reset;
    do_reset();
    u_bus.HREADY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      strobe(32'h600 + 32'(i), 8'(8'h10 + i));
      tick();
    end
    u_bus.write_enable = 1'b0;
    n_tests++; if (overflow !== 1'b1 || busy !== 1'b1 || u_bus.HTRANS !== 2'b10)
      begin n_fail++; $display("FAIL arst_pre got ovf=%b busy=%b htrans=%h want 1/1/2", overflow, busy, u_bus.HTRANS); end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++; if (u_bus.HTRANS !== 2'b00 || u_bus.HWRITE !== 1'b0)
      begin n_fail++; $display("FAIL arst_htrans got %h/%b want 0/0", u_bus.HTRANS, u_bus.HWRITE); end
    n_tests++; if ({busy, overflow, bus_error} !== 3'b000)
      begin n_fail++; $display("FAIL arst_flags got %b want 000", {busy, overflow, bus_error}); end
    n_tests++; if (u_bus.HADDR !== 32'h0 || u_bus.HWDATA !== 32'h0)
      begin n_fail++; $display("FAIL arst_bus got %h/%h want 0/0", u_bus.HADDR, u_bus.HWDATA); end
    tick();
    reset_n = 1'b1;
    u_bus.HREADY = 1'b1;
    strobe(32'h500, 8'hC3);
    tick();
    u_bus.write_enable = 1'b0;
    tick();
    n_tests++; if (u_bus.HTRANS !== 2'b10 || u_bus.HADDR !== 32'h500)
      begin n_fail++; $display("FAIL arst_after_addr got %h/%h want 2/500", u_bus.HTRANS, u_bus.HADDR); end
    tick();
    n_tests++; if (u_bus.HWDATA !== 32'hC3C3_C3C3) begin n_fail++; $display("FAIL arst_after_data got %h want c3c3c3c3", u_bus.HWDATA); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_after_busy got %b want 0", busy); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wait_states();
    test_overflow();
    test_bus_error();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
